mem_port_arbiter: RTL and testbench

- Shares one external 8-bit memory port between the three mapper memory requesters: CHR (PPU side), PRG (CPU side) and SRM (save RAM).
- Sits between the mapper address/control logic and the physical memory controller.
- Each requester has a request/acknowledge handshake. CHR has strict priority, with a starvation guard. PRG and SRM are round-robin between themselves.
- Runs in the system clock domain. It sequences fixed-length accesses with a small FSM and counter.

---
 rtl/mem_port_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 8-bit external memory port between the CHR,
// PRG and SRM requesters of the mapper.
//   chr_*/prg_*/srm_* : req/ack handshake per requester, latched addr/we/wdat,
//                       registered read data held until that port's next read
//   mem_*             : registered strobes, address and write data to the
//                       memory controller; mem_din sampled on the last cycle
//   busy              : high whenever the access FSM is not idle
// CHR has priority over PRG/SRM, bounded by a starvation guard; PRG and SRM
// share the remaining slots round-robin.
module mem_port_arbiter #(
    parameter int unsigned AW      = 23,
    parameter int unsigned ACC_CYC = 3,
    parameter int unsigned STARVE  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          chr_req,
    input  logic          chr_we,
    input  logic [AW-1:0] chr_addr,
    input  logic [7:0]    chr_wdat,
    output logic          chr_ack,
    output logic [7:0]    chr_rdat,
    input  logic          prg_req,
    input  logic          prg_we,
    input  logic [AW-1:0] prg_addr,
    input  logic [7:0]    prg_wdat,
    output logic          prg_ack,
    output logic [7:0]    prg_rdat,
    input  logic          srm_req,
    input  logic          srm_we,
    input  logic [AW-1:0] srm_addr,
    input  logic [7:0]    srm_wdat,
    output logic          srm_ack,
    output logic [7:0]    srm_rdat,
    output logic          mem_ce,
    output logic          mem_oe,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_dout,
    input  logic [7:0]    mem_din,
    output logic          busy
);

    localparam int unsigned CW = 4;
    localparam int unsigned SW = 3;
    localparam logic [CW-1:0] CNT_LOAD   = CW'(ACC_CYC - 1);
    localparam logic [SW-1:0] STARVE_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        G_CHR = 2'd0,
        G_PRG = 2'd1,
        G_SRM = 2'd2
    } grant_t;

    state_t          state, state_nxt;
    grant_t          gnt, gnt_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [SW-1:0]   starve_cnt, starve_nxt;
    logic            rr, rr_nxt;
    logic            we_l, we_nxt;
    logic [AW-1:0]   addr_nxt;
    logic [7:0]      wdat_nxt;
    logic            ce_nxt, oe_nxt, mwe_nxt, busy_nxt;
    logic            chr_ack_nxt, prg_ack_nxt, srm_ack_nxt;
    logic [7:0]      chr_rdat_nxt, prg_rdat_nxt, srm_rdat_nxt;
    logic            other_req_c, chr_win_c, srm_pick_c;

    // Grant decision, only consumed in IDLE
    always_comb begin
        other_req_c = prg_req | srm_req;
        chr_win_c   = chr_req && ((STARVE == 0) || !other_req_c ||
                                  (32'(starve_cnt) < STARVE));
        srm_pick_c  = srm_req && (!prg_req || rr);
    end

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        cnt_nxt      = cnt;
        starve_nxt   = starve_cnt;
        rr_nxt       = rr;
        we_nxt       = we_l;
        addr_nxt     = mem_addr;
        wdat_nxt     = mem_dout;
        ce_nxt       = 1'b0;
        oe_nxt       = 1'b0;
        mwe_nxt      = 1'b0;
        chr_ack_nxt  = 1'b0;
        prg_ack_nxt  = 1'b0;
        srm_ack_nxt  = 1'b0;
        chr_rdat_nxt = chr_rdat;
        prg_rdat_nxt = prg_rdat;
        srm_rdat_nxt = srm_rdat;

        case (state)
            IDLE: begin
                if (chr_req || prg_req || srm_req) begin
                    state_nxt = ACC;
                    cnt_nxt   = CNT_LOAD;
                    if (chr_win_c) begin
                        gnt_nxt  = G_CHR;
                        we_nxt   = chr_we;
                        addr_nxt = chr_addr;
                        wdat_nxt = chr_wdat;
                        // Count CHR wins only while someone else is waiting
                        if (!other_req_c)
                            starve_nxt = '0;
                        else if (starve_cnt != STARVE_MAX)
                            starve_nxt = starve_cnt + SW'(1);
                    end else if (srm_pick_c) begin
                        gnt_nxt    = G_SRM;
                        we_nxt     = srm_we;
                        addr_nxt   = srm_addr;
                        wdat_nxt   = srm_wdat;
                        rr_nxt     = 1'b0;
                        starve_nxt = '0;
                    end else begin
                        gnt_nxt    = G_PRG;
                        we_nxt     = prg_we;
                        addr_nxt   = prg_addr;
                        wdat_nxt   = prg_wdat;
                        rr_nxt     = 1'b1;
                        starve_nxt = '0;
                    end
                    ce_nxt  = 1'b1;
                    oe_nxt  = !we_nxt;
                    mwe_nxt = we_nxt;
                end
            end
            ACC: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                    case (gnt)
                        G_CHR: begin
                            chr_ack_nxt = 1'b1;
                            if (!we_l) chr_rdat_nxt = mem_din;
                        end
                        G_PRG: begin
                            prg_ack_nxt = 1'b1;
                            if (!we_l) prg_rdat_nxt = mem_din;
                        end
                        default: begin
                            srm_ack_nxt = 1'b1;
                            if (!we_l) srm_rdat_nxt = mem_din;
                        end
                    endcase
                end else begin
                    cnt_nxt = cnt - CW'(1);
                    ce_nxt  = 1'b1;
                    oe_nxt  = !we_l;
                    mwe_nxt = we_l;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt        <= G_CHR;
            cnt        <= '0;
            starve_cnt <= '0;
            rr         <= 1'b0;
            we_l       <= 1'b0;
            mem_addr   <= '0;
            mem_dout   <= '0;
            mem_ce     <= 1'b0;
            mem_oe     <= 1'b0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
            chr_ack    <= 1'b0;
            prg_ack    <= 1'b0;
            srm_ack    <= 1'b0;
            chr_rdat   <= '0;
            prg_rdat   <= '0;
            srm_rdat   <= '0;
        end else begin
            state      <= state_nxt;
            gnt        <= gnt_nxt;
            cnt        <= cnt_nxt;
            starve_cnt <= starve_nxt;
            rr         <= rr_nxt;
            we_l       <= we_nxt;
            mem_addr   <= addr_nxt;
            mem_dout   <= wdat_nxt;
            mem_ce     <= ce_nxt;
            mem_oe     <= oe_nxt;
            mem_we     <= mwe_nxt;
            busy       <= busy_nxt;
            chr_ack    <= chr_ack_nxt;
            prg_ack    <= prg_ack_nxt;
            srm_ack    <= srm_ack_nxt;
            chr_rdat   <= chr_rdat_nxt;
            prg_rdat   <= prg_rdat_nxt;
            srm_rdat   <= srm_rdat_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a vector table of single accesses plus
// hand-written sequences for starvation, round-robin, mid-access reset and
// early request drop. Port index 0 = CHR, 1 = PRG, 2 = SRM.
module tb_mem_port_arbiter;

    localparam int unsigned AW      = 23;
    localparam int unsigned ACC_CYC = 3;
    localparam int unsigned STARVE  = 4;
    localparam int          NV      = 6;

    logic                 clk;
    logic                 rst_n;
    logic [2:0]           req, we;
    logic [2:0][AW-1:0]   addr;
    logic [2:0][7:0]      wdat;
    logic [7:0]           mem_din;

    logic [2:0]           ack;
    logic [2:0][7:0]      rdat;
    logic                 mem_ce, mem_oe, mem_we, busy;
    logic [AW-1:0]        mem_addr;
    logic [7:0]           mem_dout;

    // Second instance with the starvation guard disabled
    logic [2:0]           ack0;
    logic [2:0][7:0]      rdat0;
    logic                 mem0_ce, mem0_oe, mem0_we, busy0;
    logic [AW-1:0]        mem0_addr;
    logic [7:0]           mem0_dout;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.AW(AW), .ACC_CYC(ACC_CYC), .STARVE(STARVE)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .chr_req(req[0]), .chr_we(we[0]), .chr_addr(addr[0]), .chr_wdat(wdat[0]),
        .chr_ack(ack[0]), .chr_rdat(rdat[0]),
        .prg_req(req[1]), .prg_we(we[1]), .prg_addr(addr[1]), .prg_wdat(wdat[1]),
        .prg_ack(ack[1]), .prg_rdat(rdat[1]),
        .srm_req(req[2]), .srm_we(we[2]), .srm_addr(addr[2]), .srm_wdat(wdat[2]),
        .srm_ack(ack[2]), .srm_rdat(rdat[2]),
        .mem_ce(mem_ce), .mem_oe(mem_oe), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
        .busy(busy)
    );

    mem_port_arbiter #(.AW(AW), .ACC_CYC(ACC_CYC), .STARVE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .chr_req(req[0]), .chr_we(we[0]), .chr_addr(addr[0]), .chr_wdat(wdat[0]),
        .chr_ack(ack0[0]), .chr_rdat(rdat0[0]),
        .prg_req(req[1]), .prg_we(we[1]), .prg_addr(addr[1]), .prg_wdat(wdat[1]),
        .prg_ack(ack0[1]), .prg_rdat(rdat0[1]),
        .srm_req(req[2]), .srm_we(we[2]), .srm_addr(addr[2]), .srm_wdat(wdat[2]),
        .srm_ack(ack0[2]), .srm_rdat(rdat0[2]),
        .mem_ce(mem0_ce), .mem_oe(mem0_oe), .mem_we(mem0_we),
        .mem_addr(mem0_addr), .mem_dout(mem0_dout), .mem_din(mem_din),
        .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              port;
        logic            we;
        logic [AW-1:0]   addr;
        logic [7:0]      wdat;
        logic [7:0]      din;
        logic [2:0][7:0] exp_rdat;   // {srm, prg, chr} after the access
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_seq();
        rst_n   = 1'b0;
        req     = '0;
        we      = '0;
        addr    = '0;
        wdat    = '0;
        mem_din = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int lat, got, multi, c0_chr, c0_prg, cnt_ack;
        int order [6];
        int times [4];
        int exp_order [6];

        vecs[0] = '{1, 1'b0, 23'h001234, 8'hEE, 8'h5A, {8'h00, 8'h5A, 8'h00}};
        vecs[1] = '{2, 1'b1, 23'h001FFF, 8'hC3, 8'h00, {8'h00, 8'h5A, 8'h00}};
        vecs[2] = '{0, 1'b0, 23'h7FFFFF, 8'h11, 8'hA5, {8'h00, 8'h5A, 8'hA5}};
        vecs[3] = '{0, 1'b1, 23'h000000, 8'h3C, 8'hFF, {8'h00, 8'h5A, 8'hA5}};
        vecs[4] = '{2, 1'b0, 23'h400000, 8'h22, 8'h81, {8'h81, 8'h5A, 8'hA5}};
        vecs[5] = '{1, 1'b1, 23'h2AAAAA, 8'h00, 8'h77, {8'h81, 8'h5A, 8'hA5}};

        // Reset state
        rst_seq();
        check("reset_outputs",
              64'({mem_ce, mem_oe, mem_we, busy, ack, mem_addr, mem_dout, rdat}), 64'(0));
        check("reset_outputs_dut0",
              64'({mem0_ce, mem0_oe, mem0_we, busy0, ack0, mem0_addr, mem0_dout, rdat0}), 64'(0));
        tick();
        check("idle_no_req", 64'({busy, mem_ce, ack}), 64'(0));

        // Table of single accesses
        for (int v = 0; v < NV; v++) begin
            int p;
            p   = vecs[v].port;
            lat = 0;
            req[p]  = 1'b1;
            we[p]   = vecs[v].we;
            addr[p] = vecs[v].addr;
            wdat[p] = vecs[v].wdat;
            mem_din = vecs[v].din;
            for (int n = 1; n <= 20 && lat == 0; n++) begin
                tick();
                if (ack[p]) lat = n;
                else if (n <= int'(ACC_CYC))
                    check($sformatf("v%0d_strobe_c%0d", v, n),
                          64'({mem_ce, mem_oe, mem_we, mem_addr, mem_dout}),
                          64'({1'b1, !vecs[v].we, vecs[v].we, vecs[v].addr, vecs[v].wdat}));
            end
            req[p] = 1'b0;
            check($sformatf("v%0d_ack_latency", v), 64'(lat), 64'(ACC_CYC + 1));
            check($sformatf("v%0d_done_state", v),
                  64'({mem_ce, mem_oe, mem_we, ack}), 64'(3'b001 << p));
            tick();
            check($sformatf("v%0d_rdat", v), 64'(rdat), 64'(vecs[v].exp_rdat));
            check($sformatf("v%0d_back_idle", v), 64'({busy, ack}), 64'(0));
        end

        // Starvation guard: CHR and PRG held
        rst_seq();
        req[0] = 1'b1;
        req[1] = 1'b1;
        mem_din = 8'h11;
        exp_order = '{0, 0, 0, 0, 1, 0};
        got = 0; multi = 0; c0_chr = 0; c0_prg = 0;
        for (int n = 1; n <= 60 && got < 6; n++) begin
            tick();
            if ($countones(ack) > 1) multi++;
            if (ack != 3'b000) begin
                order[got] = ack[0] ? 0 : (ack[1] ? 1 : 2);
                got++;
            end
            if (ack0[0]) c0_chr++;
            if (ack0[1]) c0_prg++;
        end
        req = '0;
        check("starve_grant_count", 64'(got), 64'(6));
        for (int i = 0; i < 6; i++)
            if (i < got)
                check($sformatf("starve_order_%0d", i), 64'(order[i]), 64'(exp_order[i]));
        check("starve_multi_ack", 64'(multi), 64'(0));
        check("noguard_prg_grants", 64'(c0_prg), 64'(0));
        check("noguard_chr_grants", 64'(c0_chr), 64'(6));
        for (int i = 0; i < 6; i++) tick();

        // Round-robin between PRG and SRM, both held
        rst_seq();
        req[1] = 1'b1;
        req[2] = 1'b1;
        got = 0;
        for (int n = 1; n <= 40 && got < 4; n++) begin
            tick();
            if (ack != 3'b000) begin
                order[got] = ack[0] ? 0 : (ack[1] ? 1 : 2);
                times[got] = n;
                got++;
            end
        end
        req = '0;
        check("rr_grant_count", 64'(got), 64'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < got) begin
                check($sformatf("rr_order_%0d", i), 64'(order[i]), 64'((i % 2 == 0) ? 1 : 2));
                check($sformatf("rr_time_%0d", i),
                      64'((i == 0) ? times[0] : times[i] - times[i-1]),
                      64'((i == 0) ? ACC_CYC + 1 : ACC_CYC + 2));
            end
        end
        for (int i = 0; i < 6; i++) tick();

        // Reset during the second ACC cycle of a CHR read
        rst_seq();
        req[0]  = 1'b1;
        addr[0] = 23'h123456;
        mem_din = 8'h99;
        tick();
        tick();
        check("midrst_in_acc", 64'({mem_ce, mem_oe, mem_addr}), 64'({2'b11, 23'h123456}));
        rst_n = 1'b0;
        #1;
        check("midrst_async_clear",
              64'({mem_ce, mem_oe, mem_we, busy, ack, mem_addr, mem_dout, rdat}), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        lat = 0; cnt_ack = 0;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            tick();
            if (ack[0]) begin
                lat = n;
                cnt_ack++;
            end
        end
        req[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack[0]) cnt_ack++;
        end
        check("midrst_ack_latency", 64'(lat), 64'(ACC_CYC + 1));
        check("midrst_ack_count", 64'(cnt_ack), 64'(1));
        check("midrst_rdat", 64'(rdat[0]), 64'(8'h99));

        // PRG drops its request during ACC
        req[1]  = 1'b1;
        we[1]   = 1'b0;
        addr[1] = 23'h00ABCD;
        mem_din = 8'h42;
        lat = 0; cnt_ack = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 1) req[1] = 1'b0;
            if (ack[1]) begin
                if (lat == 0) lat = n;
                cnt_ack++;
            end
        end
        check("drop_ack_latency", 64'(lat), 64'(ACC_CYC + 1));
        check("drop_ack_count", 64'(cnt_ack), 64'(1));
        check("drop_rdat", 64'(rdat[1]), 64'(8'h42));
        check("drop_idle", 64'({busy, mem_ce}), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
